// File: rtl/switch_debouncer_if.sv
// rtl/switch_debouncer_if.sv - switch debouncer signal bundle
// The board/switch side is the master; the debouncer is the slave.
interface switch_debouncer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] SwitchIn;
  logic [WIDTH-1:0] SwitchOut;
  logic [WIDTH-1:0] SwitchRise;
  logic [WIDTH-1:0] SwitchFall;
  logic             Changed;

  modport master (
    output SwitchIn,
    input  SwitchOut,
    input  SwitchRise,
    input  SwitchFall,
    input  Changed
  );

  modport slave (
    input  SwitchIn,
    output SwitchOut,
    output SwitchRise,
    output SwitchFall,
    output Changed
  );
endinterface

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-bit synchronise, debounce and edge-strobe of slide switches
// Runs on the core clock; every output is registered.
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  switch_debouncer_if.slave sw
);

  // Terminal count; CNT_WIDTH must be wide enough to hold DEBOUNCE_CYCLES-1.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];
  logic [WIDTH-1:0]     out_q;
  logic [WIDTH-1:0]     rise_q;
  logic [WIDTH-1:0]     fall_q;
  logic                 changed_q;
  logic [WIDTH-1:0]     accept;

  // A bit is accepted on the edge where it still differs and the count has reached its limit.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != out_q[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1     <= '0;
      sync2     <= '0;
      out_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= sw.SwitchIn;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == out_q[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
      out_q     <= out_q ^ accept;
      rise_q    <= accept & sync2;
      fall_q    <= accept & ~sync2;
      changed_q <= |accept;
    end
  end

  assign sw.SwitchOut  = out_q;
  assign sw.SwitchRise = rise_q;
  assign sw.SwitchFall = fall_q;
  assign sw.Changed    = changed_q;

endmodule
